// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//
// Direct-mapped, write-back, write-allocate L1 data cache controller placed
// after the CPU MEM stage. Hits complete in the cycle they are presented.
// A miss raises p1_stall_o while the controller writes back a dirty victim
// (if any), refills the line from main memory and then lets the held request
// complete as a hit.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   p1_addr_i      CPU byte address (bits [1:0] ignored, word access only)
//   p1_data_i      CPU store data
//   p1_MemRead_i   CPU load request
//   p1_MemWrite_i  CPU store request (wins if both requests are high)
//   p1_data_o      load data on a read hit, 0 otherwise
//   p1_stall_o     pipeline stall; CPU holds its request while high
//   mem_addr_o     line-aligned memory address
//   mem_data_o     write-back line data
//   mem_enable_o   memory request, held until mem_ack_i
//   mem_write_o    1 = write-back, 0 = refill read
//   mem_data_i     refill line, valid with mem_ack_i
//   mem_ack_i      single-cycle completion pulse
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LINE_COUNT = 32,
    parameter int LINE_BITS  = 256,
    parameter int TAG_W      = 32 - $clog2(LINE_COUNT) - 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int OFF_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_UPDATE
    } state_t;

    state_t state_reg, state_next;

    // Line state. Only valid/dirty are reset; tag and data are qualified by
    // valid, so they are left uninitialised.
    logic [LINE_COUNT-1:0] valid_reg;
    logic [LINE_COUNT-1:0] dirty_reg;
    logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
    logic [LINE_BITS-1:0]  data_mem [LINE_COUNT];

    // Address decode
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] addr_tag;
    logic [2:0]       word_sel;
    logic             unused_addr_bits;

    assign idx              = p1_addr_i[OFF_W +: IDX_W];
    assign addr_tag         = p1_addr_i[31 -: TAG_W];
    assign word_sel         = p1_addr_i[4:2];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // Lookup
    logic                 req;
    logic                 is_write;
    logic                 is_read;
    logic                 hit;
    logic [LINE_BITS-1:0] rd_line;
    logic [31:0]          rd_word;

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_write = p1_MemWrite_i;
    assign is_read  = p1_MemRead_i & ~p1_MemWrite_i;
    assign rd_line  = data_mem[idx];
    assign rd_word  = rd_line[{word_sel, 5'b0} +: 32];
    assign hit      = valid_reg[idx] && (tag_mem[idx] == addr_tag);

    // Store-hit line: the addressed word replaced, the rest kept.
    logic [LINE_BITS-1:0] line_merged;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_BITS / 32; gi++) begin : g_word_merge
            assign line_merged[gi*32 +: 32] =
                (word_sel == 3'(gi)) ? p1_data_i : rd_line[gi*32 +: 32];
        end
    endgenerate

    // Write enables. Store hits only commit from IDLE so a store that missed
    // lands on the refilled line one cycle after UPDATE.
    logic refill_we;
    logic word_we;

    assign word_we = (state_reg == S_IDLE) && is_write && hit;

    // Outputs to the pipeline. Gated with rst_i so they drop as soon as reset
    // is asserted, even while the CPU still holds a request.
    assign p1_stall_o = rst_i && ((req && !hit) || (state_reg != S_IDLE));
    assign p1_data_o  = (rst_i && is_read && hit) ? rd_word : 32'h0;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and memory-side outputs
    always_comb begin
        state_next   = state_reg;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = '0;
        refill_we    = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (req && !hit) begin
                    if (valid_reg[idx] && dirty_reg[idx]) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        state_next = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                // Victim address is rebuilt from the stored tag, not the CPU tag.
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[idx], idx, 5'b0};
                mem_data_o   = rd_line;
                if (mem_ack_i) begin
                    state_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {p1_addr_i[31:OFF_W], 5'b0};
                if (mem_ack_i) begin
                    refill_we  = 1'b1;
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // One settling cycle; the held request then hits in IDLE.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Valid / dirty bits
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (refill_we) begin
            valid_reg[idx] <= 1'b1;
            dirty_reg[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_reg[idx] <= 1'b1;
        end
    end

    // Tag and data arrays
    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            data_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= addr_tag;
        end else if (word_we) begin
            data_mem[idx] <= line_merged;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t         txn_q[$];
    logic [255:0] mem_model [int unsigned];   // backing memory, keyed by line
    logic [31:0]  arch      [int unsigned];   // CPU-visible stores, keyed by word
    bit           ref_valid [32];
    bit           ref_dirty [32];
    bit   [21:0]  ref_tag   [32];
    int           wb_lat = 1;
    int           rf_lat = 1;
    int           resp_cnt = 0;
    int           compared = 0;
    int           mismatched = 0;
    logic [31:0]  rd_data;
    int           stall_cnt;

    // Backing memory content; untouched lines follow a fixed pattern.
    function automatic logic [255:0] mem_line(input int unsigned key);
        logic [255:0] l;
        if (mem_model.exists(key)) return mem_model[key];
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (((key << 5) | (w << 2)) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        end
        return l;
    endfunction

    // Value the CPU should observe at a word address.
    function automatic logic [31:0] arch_word(input logic [31:0] a);
        int unsigned  k;
        logic [255:0] l;
        k = a[31:2];
        if (arch.exists(k)) return arch[k];
        l = mem_line(a[31:5]);
        return l[a[4:2]*32 +: 32];
    endfunction

    // Memory responder: ack on the N-th consecutive enabled cycle of a
    // transaction, N = wb_lat for write-back, rf_lat for refill.
    initial begin
        int unsigned key;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i  = 1'b0;
            mem_data_i = {8{$urandom}};
            if (rst_i !== 1'b1) begin
                resp_cnt = 0;
            end else if (mem_enable_o === 1'b1) begin
                resp_cnt++;
                if (resp_cnt >= (mem_write_o ? wb_lat : rf_lat)) begin
                    resp_cnt  = 0;
                    mem_ack_i = 1'b1;
                    key       = mem_addr_o[31:5];
                    if (mem_write_o) mem_model[key] = mem_data_o;
                    else             mem_data_i = mem_line(key);
                    txn_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    // One CPU access, held until the stall drops, checked against the model.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input bit rd,
                          input bit wr, input int wbl, input int rfl,
                          output logic [31:0] dout, output int stalls);
        int           idx, exp_stalls, guard, exp_txn;
        bit   [21:0]  tag;
        bit           hit, vdirty;
        logic [31:0]  victim, fill_addr, exp_data;
        logic [255:0] wb_line;
        idx       = int'(a[9:5]);
        tag       = a[31:10];
        hit       = ref_valid[idx] && (ref_tag[idx] == tag);
        vdirty    = !hit && ref_valid[idx] && ref_dirty[idx];
        victim    = {ref_tag[idx], a[9:5], 5'b0};
        fill_addr = {a[31:5], 5'b0};
        for (int w = 0; w < 8; w++) wb_line[w*32 +: 32] = arch_word(victim + 32'(w * 4));
        exp_stalls = hit ? 0 : ((vdirty ? wbl : 0) + rfl + 2);
        exp_txn    = hit ? 0 : (vdirty ? 2 : 1);
        txn_q.delete();

        @(negedge clk_i);
        wb_lat = wbl;
        rf_lat = rfl;
        p1_addr_i = a; p1_data_i = wd; p1_MemRead_i = rd; p1_MemWrite_i = wr;
        #1;
        compared++;
        if (p1_stall_o !== !hit) begin
            mismatched++;
            $display("FAIL stall_on_request @%h: got %b expected %b", a, p1_stall_o, !hit);
        end
        stalls = 0;
        guard  = 0;
        while (p1_stall_o === 1'b1 && guard < 200) begin
            stalls++;
            if (mem_enable_o === 1'b1) begin
                compared++;
                if (mem_write_o === 1'b1) begin
                    if (!vdirty || mem_addr_o !== victim) begin
                        mismatched++;
                        $display("FAIL wb_addr @%h: got %h expected %h (victim dirty=%0d)",
                                 a, mem_addr_o, victim, vdirty);
                    end
                end else if (mem_addr_o !== fill_addr) begin
                    mismatched++;
                    $display("FAIL refill_addr @%h: got %h expected %h", a, mem_addr_o, fill_addr);
                end
            end
            @(negedge clk_i);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL stall_timeout @%h: got stall after %0d cycles expected release", a, guard);
        end
        compared++;
        if (stalls != exp_stalls) begin
            mismatched++;
            $display("FAIL stall_cycles @%h: got %0d expected %0d", a, stalls, exp_stalls);
        end
        exp_data = (rd && !wr) ? arch_word(a) : 32'h0;
        compared++;
        if (p1_data_o !== exp_data) begin
            mismatched++;
            $display("FAIL load_data @%h: got %h expected %h", a, p1_data_o, exp_data);
        end
        compared++;
        if (mem_enable_o !== 1'b0) begin
            mismatched++;
            $display("FAIL mem_enable_done @%h: got %b expected 0", a, mem_enable_o);
        end
        compared++;
        if (txn_q.size() != exp_txn) begin
            mismatched++;
            $display("FAIL txn_count @%h: got %0d expected %0d", a, txn_q.size(), exp_txn);
        end
        if (vdirty && txn_q.size() == 2) begin
            compared++;
            if (txn_q[0].wr !== 1'b1 || txn_q[0].data !== wb_line) begin
                mismatched++;
                $display("FAIL wb_data @%h: got wr=%b %h expected wr=1 %h",
                         a, txn_q[0].wr, txn_q[0].data, wb_line);
            end
        end
        if (!hit && txn_q.size() > 0) begin
            compared++;
            if (txn_q[$].wr !== 1'b0 || txn_q[$].addr !== fill_addr) begin
                mismatched++;
                $display("FAIL refill_txn @%h: got wr=%b %h expected wr=0 %h",
                         a, txn_q[$].wr, txn_q[$].addr, fill_addr);
            end
        end
        dout = p1_data_o;
        if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_dirty[idx] = 1'b1;
            arch[a[31:2]]  = wd;
        end
        $display("txn addr=%h rd=%0d wr=%0d wdata=%h hit=%0d stalls=%0d rdata=%h",
                 a, rd, wr, wd, hit, stalls, dout);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        arch.delete();
        txn_q.delete();
    endtask

    task automatic test_reset();
        logic [255:0] l;
        l = mem_line(2);
        l[31:0]  = 32'hDEAD_BEEF;
        l[63:32] = 32'h1111_2222;
        mem_model[2] = l;
        clear_model();
        rst_i = 1'b0;
        p1_addr_i = 32'h40; p1_data_i = 32'h0; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        compared++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_cpu_side: got stall=%b data=%h expected 0 0", p1_stall_o, p1_data_o);
        end
        compared++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_mem_side: got en=%b wr=%b addr=%h expected 0 0 0",
                     mem_enable_o, mem_write_o, mem_addr_o);
        end
        @(negedge clk_i);
        p1_MemRead_i = 1'b0;
        rst_i = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_refill();
        access(32'h40, 32'h0, 1'b1, 1'b0, 1, 3, rd_data, stall_cnt);
        compared++;
        if (rd_data !== 32'hDEAD_BEEF || stall_cnt != 5) begin
            mismatched++;
            $display("FAIL refill_0x40: got data=%h stalls=%0d expected DEADBEEF 5", rd_data, stall_cnt);
        end
    endtask

    task automatic test_hit();
        access(32'h44, 32'h0, 1'b1, 1'b0, 1, 1, rd_data, stall_cnt);
        compared++;
        if (rd_data !== 32'h1111_2222 || stall_cnt != 0) begin
            mismatched++;
            $display("FAIL hit_0x44: got data=%h stalls=%0d expected 11112222 0", rd_data, stall_cnt);
        end
    endtask

    task automatic test_write_hit();
        access(32'h48, 32'hCAFE_0001, 1'b0, 1'b1, 1, 1, rd_data, stall_cnt);
        access(32'h48, 32'h0, 1'b1, 1'b0, 1, 1, rd_data, stall_cnt);
        compared++;
        if (rd_data !== 32'hCAFE_0001 || stall_cnt != 0) begin
            mismatched++;
            $display("FAIL write_hit_0x48: got data=%h stalls=%0d expected CAFE0001 0", rd_data, stall_cnt);
        end
    endtask

    task automatic test_evict();
        access(32'h448, 32'h0, 1'b1, 1'b0, 2, 3, rd_data, stall_cnt);
        compared++;
        if (stall_cnt != 7) begin
            mismatched++;
            $display("FAIL evict_stalls: got %0d expected 7", stall_cnt);
        end
        compared++;
        if (txn_q.size() < 2) begin
            mismatched++;
            $display("FAIL evict_txns: got %0d expected 2", txn_q.size());
        end else if (txn_q[0].addr !== 32'h40 || txn_q[0].data[95:64] !== 32'hCAFE_0001 ||
                     txn_q[1].addr !== 32'h440) begin
            mismatched++;
            $display("FAIL evict_txns: got wb=%h w2=%h rf=%h expected 00000040 CAFE0001 00000440",
                     txn_q[0].addr, txn_q[0].data[95:64], txn_q[1].addr);
        end
    endtask

    task automatic test_reset_mid_alloc();
        int guard;
        @(negedge clk_i);
        rf_lat = 20;
        p1_addr_i = 32'h40; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
        guard = 0;
        while (!(mem_enable_o === 1'b1 && mem_write_o === 1'b0) && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        repeat (2) @(negedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        compared++;
        if (guard >= 50 || mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_alloc: got en=%b stall=%b wait=%0d expected 0 0 <50",
                     mem_enable_o, p1_stall_o, guard);
        end
        @(negedge clk_i);
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_model();
        $display("txn reset during allocate");
        access(32'h40, 32'h0, 1'b1, 1'b0, 1, 2, rd_data, stall_cnt);
        compared++;
        if (stall_cnt != 4 || rd_data !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL reread_after_reset: got stalls=%0d data=%h expected 4 DEADBEEF", stall_cnt, rd_data);
        end
    endtask

    task automatic test_both_high();
        access(32'h40, 32'h0BAD_F00D, 1'b1, 1'b1, 1, 1, rd_data, stall_cnt);
        compared++;
        if (stall_cnt != 0 || rd_data !== 32'h0) begin
            mismatched++;
            $display("FAIL both_high_store: got stalls=%0d data=%h expected 0 0", stall_cnt, rd_data);
        end
        access(32'h440, 32'h0, 1'b1, 1'b0, 1, 1, rd_data, stall_cnt);
        compared++;
        if (stall_cnt != 4 || txn_q.size() < 1 || txn_q[0].wr !== 1'b1 ||
            txn_q[0].data[31:0] !== 32'h0BAD_F00D) begin
            mismatched++;
            $display("FAIL both_high_evict: got stalls=%0d txns=%0d expected 4 with write-back of 0BADF00D",
                     stall_cnt, txn_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 8; w++) begin
            access(32'h440 + 32'(w * 4), 32'hB000_0000 + 32'(w), 1'b0, 1'b1, 1, 1, rd_data, stall_cnt);
        end
        for (int w = 0; w < 8; w++) begin
            access(32'h440 + 32'(w * 4), 32'h0, 1'b1, 1'b0, 1, 1, rd_data, stall_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int          m;
            a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            m = $urandom_range(0, 2);
            access(a, $urandom, (m != 1), (m != 0), $urandom_range(1, 4), $urandom_range(1, 4),
                   rd_data, stall_cnt);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        p1_addr_i = 32'h0; p1_data_i = 32'h0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        test_reset();
        test_refill();
        test_hit();
        test_write_hit();
        test_evict();
        test_reset_mid_alloc();
        test_both_high();
        test_back_to_back();
        test_random();
        @(negedge clk_i);
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
